// File: rtl/fir_route_ctrl_pkg.sv
// Shared definitions for the FIR input router: state encoding, lane indices
// and the burst-counter width helper.
package fir_route_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST_A = 2'd1,
        ST_BURST_B = 2'd2
    } fir_state_e;

    localparam int LANE_A = 0;
    localparam int LANE_B = 1;

    // A one-sample burst still needs a one-bit counter.
    function automatic int cnt_width(input int blk_len);
        return (blk_len > 1) ? $clog2(blk_len) : 1;
    endfunction

endpackage

// File: rtl/fir_route_ctrl_lane_reg.sv
// Single-entry valid/ready output register feeding one downstream FIR lane.
module fir_lane_reg #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [N-1:0] data
);

    logic         valid_q, valid_d;
    logic [N-1:0] data_q, data_d;

    // A load in the same cycle as a drain keeps the register full with new data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/fir_route_ctrl.sv
// Routes an upstream sample stream into two FIR lanes in fixed-length bursts,
// alternating lanes when both are enabled.
module fir_route_ctrl
    import fir_route_ctrl_pkg::*;
#(
    parameter int N       = 16,
    parameter int BLK_LEN = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   lane_en,
    output logic [N-1:0] a_data,
    output logic [N-1:0] b_data,
    output logic         a_valid,
    output logic         b_valid,
    input  logic         a_ready,
    input  logic         b_ready,
    output logic         sel,
    output logic         burst_done
);

    localparam int               CNT_W    = cnt_width(BLK_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_LEN - 1);

    fir_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             accept, load_a, load_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // lane_en is only consulted in IDLE and on the last transfer of a burst.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (lane_en[LANE_A])      state_d = ST_BURST_A;
                else if (lane_en == 2'b10) state_d = ST_BURST_B;
            end
            ST_BURST_A, ST_BURST_B: begin
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (state_q == ST_BURST_A)
                            state_d = lane_en[LANE_B] ? ST_BURST_B :
                                      lane_en[LANE_A] ? ST_BURST_A : ST_IDLE;
                        else
                            state_d = lane_en[LANE_A] ? ST_BURST_A :
                                      lane_en[LANE_B] ? ST_BURST_B : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        sel_d = (state_d == ST_BURST_B);
    end

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_BURST_A: in_ready = !a_valid || a_ready;
            ST_BURST_B: in_ready = !b_valid || b_ready;
            default:    in_ready = 1'b0;
        endcase
        accept     = in_valid && in_ready;
        burst_done = accept && (cnt_q == CNT_LAST);
        load_a     = accept && (state_q == ST_BURST_A);
        load_b     = accept && (state_q == ST_BURST_B);
    end

    assign sel = sel_q;

    fir_lane_reg #(.N(N)) u_lane_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_a),
        .load_data (in_data),
        .ready     (a_ready),
        .valid     (a_valid),
        .data      (a_data)
    );

    fir_lane_reg #(.N(N)) u_lane_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_b),
        .load_data (in_data),
        .ready     (b_ready),
        .valid     (b_valid),
        .data      (b_data)
    );

endmodule

// File: tb/tb_fir_route_ctrl.sv
// Directed bench for fir_route_ctrl with BLK_LEN=4: a cycle table for the
// alternating-burst stream plus hand-written multi-cycle sequences.
module tb_fir_route_ctrl;

    localparam int N       = 16;
    localparam int BLK_LEN = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   lane_en = 2'b00;
    logic [N-1:0] a_data, b_data;
    logic         a_valid, b_valid;
    logic         a_ready = 1'b0, b_ready = 1'b0;
    logic         sel, burst_done;

    fir_route_ctrl #(.N(N), .BLK_LEN(BLK_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lane_en    (lane_en),
        .a_data     (a_data),
        .b_data     (b_data),
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .a_ready    (a_ready),
        .b_ready    (b_ready),
        .sel        (sel),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         vld;
        logic [N-1:0] din;
        logic [1:0]   en;
        logic         ar, br;
        logic         e_rdy, e_sel, e_done, e_av;
        logic [N-1:0] e_ad;
        logic         e_bv;
        logic [N-1:0] e_bdat;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [N-1:0] qa[$];
    logic [N-1:0] qb[$];
    logic [N-1:0] exp_q[$];
    int bd_idx[$];
    int acc_cnt = 0;
    logic saw_sel1 = 1'b0;
    logic saw_bvalid = 1'b0;
    vec_t vecs[15];

    function automatic vec_t mk(int vld, int din, int en, int rdy, int sl, int dn,
                                int av, int ad, int bv, int bd);
        vec_t v;
        v.vld = vld[0]; v.din = N'(din); v.en = en[1:0]; v.ar = 1'b1; v.br = 1'b1;
        v.e_rdy = rdy[0]; v.e_sel = sl[0]; v.e_done = dn[0];
        v.e_av = av[0]; v.e_ad = N'(ad); v.e_bv = bv[0]; v.e_bdat = N'(bd);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_q(input string nm, input logic [N-1:0] got[$], input logic [N-1:0] exp[$]);
        chk({nm, "_len"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), 32'(got[i]), 32'(exp[i]));
    endtask

    task automatic fill_exp(input int first, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(N'(first + i));
    endtask

    // One clock: drive at negedge, observe 1ns later, record lane deliveries.
    task automatic cyc(input logic vld, input logic [N-1:0] d, input logic [1:0] en,
                       input logic ar, input logic br, output logic acc);
        @(negedge clk);
        in_valid = vld; in_data = d; lane_en = en; a_ready = ar; b_ready = br;
        #1;
        acc = in_valid && in_ready;
        if (a_valid && a_ready) qa.push_back(a_data);
        if (b_valid && b_ready) qb.push_back(b_data);
        if (sel) saw_sel1 = 1'b1;
        if (b_valid) saw_bvalid = 1'b1;
        if (acc && burst_done) bd_idx.push_back(acc_cnt);
        if (acc) acc_cnt++;
    endtask

    task automatic feed(input int n, input int first, input logic [1:0] en,
                        input logic ar, input logic br);
        int sent = 0;
        int budget = 0;
        logic acc;
        while (sent < n && budget < 200) begin
            cyc(1'b1, N'(first + sent), en, ar, br, acc);
            if (acc) sent++;
            budget++;
        end
        if (sent < n) chk("feed_timeout", sent, n);
    endtask

    task automatic idle_cycles(input int n, input logic [1:0] en);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, en, 1'b1, 1'b1, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; lane_en = 2'b00; a_ready = 1'b0; b_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        qa.delete(); qb.delete(); bd_idx.delete();
        acc_cnt = 0; saw_sel1 = 1'b0; saw_bvalid = 1'b0;
    endtask

    initial begin
        logic acc;

        //            vld din en rdy sel dn av ad bv bd
        vecs[0]  = mk(1,  1, 3, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1,  1, 3, 1, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1,  2, 3, 1, 0, 0, 1, 1, 0, 0);
        vecs[3]  = mk(1,  3, 3, 1, 0, 0, 1, 2, 0, 0);
        vecs[4]  = mk(1,  4, 3, 1, 0, 1, 1, 3, 0, 0);
        vecs[5]  = mk(1,  5, 3, 1, 1, 0, 1, 4, 0, 0);
        vecs[6]  = mk(1,  6, 3, 1, 1, 0, 0, 0, 1, 5);
        vecs[7]  = mk(1,  7, 3, 1, 1, 0, 0, 0, 1, 6);
        vecs[8]  = mk(1,  8, 3, 1, 1, 1, 0, 0, 1, 7);
        vecs[9]  = mk(1,  9, 3, 1, 0, 0, 0, 0, 1, 8);
        vecs[10] = mk(1, 10, 3, 1, 0, 0, 1, 9, 0, 0);
        vecs[11] = mk(1, 11, 3, 1, 0, 0, 1, 10, 0, 0);
        vecs[12] = mk(1, 12, 3, 1, 0, 1, 1, 11, 0, 0);
        vecs[13] = mk(0,  0, 3, 1, 1, 0, 1, 12, 0, 0);
        vecs[14] = mk(0,  0, 3, 1, 1, 0, 0, 0, 0, 0);

        // Reset state
        #2;
        chk("rst_state", {in_ready, sel, burst_done, a_valid, b_valid}, 0);
        chk("rst_data", {a_data, b_data}, 0);
        do_reset();

        // Alternating bursts, both lanes enabled
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = vecs[i].vld; in_data = vecs[i].din; lane_en = vecs[i].en;
            a_ready = vecs[i].ar; b_ready = vecs[i].br;
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_rdy);
            chk($sformatf("v%0d_sel", i), sel, vecs[i].e_sel);
            chk($sformatf("v%0d_burst_done", i), burst_done, vecs[i].e_done);
            chk($sformatf("v%0d_a_valid", i), a_valid, vecs[i].e_av);
            chk($sformatf("v%0d_b_valid", i), b_valid, vecs[i].e_bv);
            if (vecs[i].e_av) chk($sformatf("v%0d_a_data", i), a_data, vecs[i].e_ad);
            if (vecs[i].e_bv) chk($sformatf("v%0d_b_data", i), b_data, vecs[i].e_bdat);
        end

        // Lane A only, 10 samples
        do_reset();
        feed(10, 101, 2'b01, 1'b1, 1'b1);
        idle_cycles(3, 2'b01);
        fill_exp(101, 10);
        chk_q("a_only_qa", qa, exp_q);
        chk("a_only_sel_never1", saw_sel1, 0);
        chk("a_only_bvalid_never1", saw_bvalid, 0);
        chk("a_only_bd_cnt", bd_idx.size(), 2);
        if (bd_idx.size() == 2) begin
            chk("a_only_bd0", bd_idx[0], 3);
            chk("a_only_bd1", bd_idx[1], 7);
        end

        // Backpressure on lane A for 3 cycles
        do_reset();
        cyc(1'b1, 16'd1, 2'b01, 1'b1, 1'b1, acc);
        chk("bp_idle_rdy", in_ready, 0);
        cyc(1'b1, 16'd1, 2'b01, 1'b1, 1'b1, acc);
        chk("bp_acc1", acc, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'd2, 2'b01, 1'b0, 1'b1, acc);
            chk($sformatf("bp_stall%0d_rdy", i), in_ready, 0);
            chk($sformatf("bp_stall%0d_av", i), a_valid, 1);
            chk($sformatf("bp_stall%0d_ad", i), a_data, 1);
        end
        feed(3, 2, 2'b01, 1'b1, 1'b1);
        idle_cycles(2, 2'b01);
        fill_exp(1, 4);
        chk_q("bp_qa", qa, exp_q);

        // lane_en drops lane A after sample 2 of the first burst
        do_reset();
        feed(2, 1, 2'b11, 1'b1, 1'b1);
        feed(10, 3, 2'b10, 1'b1, 1'b1);
        idle_cycles(3, 2'b10);
        fill_exp(1, 4);
        chk_q("switch_qa", qa, exp_q);
        fill_exp(5, 8);
        chk_q("switch_qb", qb, exp_q);

        // No lanes enabled
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 16'd7, 2'b00, 1'b1, 1'b1, acc);
            chk($sformatf("none_c%0d", i), {in_ready, a_valid, b_valid, sel}, 0);
        end

        // Asynchronous reset mid-burst with both lane registers occupied
        do_reset();
        feed(4, 1, 2'b11, 1'b1, 1'b1);
        feed(2, 5, 2'b11, 1'b0, 1'b1);
        #1;
        chk("pre_rst_av_sel", {a_valid, sel}, 2'b11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", {a_valid, b_valid, sel, in_ready, burst_done}, 0);
        chk("mid_rst_data", {a_data, b_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0; lane_en = 2'b00;
        qa.delete(); qb.delete(); bd_idx.delete(); acc_cnt = 0;
        feed(4, 21, 2'b11, 1'b1, 1'b1);
        idle_cycles(2, 2'b00);
        fill_exp(21, 4);
        chk_q("post_rst_qa", qa, exp_q);
        chk("post_rst_qb_len", qb.size(), 0);
        chk("post_rst_bd_cnt", bd_idx.size(), 1);
        if (bd_idx.size() == 1) chk("post_rst_bd_at", bd_idx[0], 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
